// File: rtl/spi_bitbang_pkg.sv
// Shared definitions for the bit-banged SPI master: FSM encoding and default word width.
package spi_bitbang_pkg;

  localparam int unsigned DefaultW    = 8;
  localparam int unsigned DefaultDivW = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } spi_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-clock step pulse every div+1 clocks from a reloading down-counter.
module tick_gen #(
  parameter int unsigned DIV_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    step    = (count_q == '0);
    count_d = step ? div : count_q - DIV_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_bitbang_master.sv
// Mode-0 SPI master fed by a first-word fall-through source; back-to-back words keep cs low.
module spi_bitbang_master
  import spi_bitbang_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned DIV_W = DefaultDivW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic [W-1:0]     in,
  input  logic             empty,
  output logic             get,
  output logic [W-1:0]     out,
  output logic             put,
  output logic             spi_cs_n,
  output logic             spi_clock,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned CntW = $clog2(W + 1);

  spi_state_e      state_q, state_d;
  logic [W-2:0]    tx_q, tx_d;  // bits still to send after the one on spi_mosi
  logic [W-1:0]    rx_q, rx_d;
  logic [W-1:0]    out_q, out_d;
  logic [CntW-1:0] bits_q, bits_d;
  logic            mosi_q, mosi_d;
  logic            step;
  logic            load;
  logic            done;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clock  (clock),
    .reset_n(reset_n),
    .div    (div),
    .step   (step)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    out_d   = out_q;
    bits_d  = bits_q;
    mosi_d  = mosi_q;
    load    = 1'b0;
    done    = 1'b0;
    if (step) begin
      unique case (state_q)
        StIdle: load = !empty;
        StLow: begin
          rx_d    = {rx_q[W-2:0], spi_miso};
          state_d = StHigh;
        end
        StHigh: begin
          if (bits_q != CntW'(1)) begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[W-2];
            bits_d  = bits_q - CntW'(1);
            state_d = StLow;
          end else begin
            done    = 1'b1;
            out_d   = rx_q;
            load    = !empty;
            mosi_d  = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
      // A load from idle or at the end of a word (burst) starts a fresh word.
      if (load) begin
        tx_d    = in[W-2:0];
        mosi_d  = in[W-1];
        bits_d  = CntW'(W);
        state_d = StLow;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tx_q    <= '0;
      rx_q    <= '0;
      out_q   <= '0;
      bits_q  <= '0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      out_q   <= out_d;
      bits_q  <= bits_d;
      mosi_q  <= mosi_d;
    end
  end

  // Strobes are combinational so the pop and the result land on the step edge itself.
  assign get       = load & reset_n;
  assign put       = done & reset_n;
  assign out       = put ? rx_q : out_q;
  assign spi_cs_n  = (state_q == StIdle);
  assign spi_clock = (state_q == StHigh);
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_bitbang_master.sv
// Directed and randomized checks of spi_bitbang_master against a word-level SPI model.
module tb_spi_bitbang_master;

  localparam int W     = 8;
  localparam int DIV_W = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [W-1:0]     in_w = '0;
  logic             empty = 1'b1;
  logic             get, put;
  logic [W-1:0]     out_w;
  logic             cs_n, sclk, mosi, miso;

  spi_bitbang_master #(
    .W    (W),
    .DIV_W(DIV_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .div      (div),
    .in       (in_w),
    .empty    (empty),
    .get      (get),
    .out      (out_w),
    .put      (put),
    .spi_cs_n (cs_n),
    .spi_clock(sclk),
    .spi_mosi (mosi),
    .spi_miso (miso)
  );

  always #5 clock = ~clock;

  // Slave model: 0 = loopback, 1 = tied high, 2 = shifts out miso_pat MSB first.
  int           miso_mode = 0;
  logic [W-1:0] miso_pat = '0;
  int           rise_in_word = 0;
  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? 1'b1 : miso_pat[W-1-(rise_in_word % W)];

  int compared = 0;
  int mismatched = 0;

  int get_cnt, put_cnt, rise_cnt, cs_fall_cnt, cs_low_cyc, mosi_viol, get_empty_viol;
  int cyc, get_cyc, put_cyc;
  logic [W-1:0] out_log[$];
  logic         mosi_bits[$];
  logic         prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;

  logic [W-1:0] src_q[$];
  logic [W-1:0] tx_words[$];

  always @(negedge clock) begin
    cyc++;
    if (get) begin
      get_cnt++;
      get_cyc = cyc;
      if (empty) get_empty_viol++;
    end
    if (put) begin
      put_cnt++;
      put_cyc = cyc;
      out_log.push_back(out_w);
    end
    if (!cs_n) cs_low_cyc++;
    if (prev_cs && !cs_n) cs_fall_cnt++;
    if (!prev_sclk && sclk) begin
      rise_cnt++;
      rise_in_word++;
      mosi_bits.push_back(mosi);
    end
    if (prev_sclk && sclk && (mosi !== prev_mosi)) mosi_viol++;
    if (cs_n) rise_in_word = 0;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_cs   = cs_n;
  end

  // First-word fall-through source: a get seen before an edge pops at that edge.
  initial begin
    logic pend;
    forever begin
      @(negedge clock);
      pend = get;
      @(posedge clock);
      #1;
      if (pend && src_q.size() > 0) void'(src_q.pop_front());
      empty = (src_q.size() == 0);
      in_w  = empty ? W'($urandom) : src_q[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    @(posedge clock);
    #1;
    get_cnt = 0; put_cnt = 0; rise_cnt = 0; cs_fall_cnt = 0; cs_low_cyc = 0;
    mosi_viol = 0; get_empty_viol = 0; get_cyc = 0; put_cyc = 0;
    out_log.delete();
    mosi_bits.delete();
  endtask

  function automatic logic [W-1:0] model_out(input logic [W-1:0] word);
    case (miso_mode)
      0:       return word;
      1:       return '1;
      default: return miso_pat;
    endcase
  endfunction

  // Sends tx_words as one burst and checks counts, timing and data against the model.
  task automatic transfer(input string tag, input int div_v);
    int n, budget, exp_low;
    logic [W-1:0] mw;
    n = tx_words.size();
    clear_stats();
    div = DIV_W'(div_v);
    foreach (tx_words[i]) src_q.push_back(tx_words[i]);
    budget = 0;
    while (!(put_cnt == n && cs_n && src_q.size() == 0) && budget < 5000) begin
      @(negedge clock);
      budget++;
    end
    if (budget >= 5000) chk({tag, "_timeout"}, 32'd1, 32'd0);
    exp_low = 2 * W * (div_v + 1) * n;
    chk({tag, "_gets"}, get_cnt, n);
    chk({tag, "_puts"}, put_cnt, n);
    chk({tag, "_cs_low_cycles"}, cs_low_cyc, exp_low);
    chk({tag, "_cs_falls"}, cs_fall_cnt, 1);
    chk({tag, "_sclk_rises"}, rise_cnt, W * n);
    chk({tag, "_mosi_stable"}, mosi_viol, 0);
    chk({tag, "_get_empty"}, get_empty_viol, 0);
    for (int i = 0; i < n; i++) begin
      if (i < out_log.size()) chk($sformatf("%s_out%0d", tag, i), out_log[i],
                                  model_out(tx_words[i]));
      else chk($sformatf("%s_out%0d_missing", tag, i), 32'd1, 32'd0);
      mw = '0;
      for (int b = 0; b < W; b++)
        if (i * W + b < mosi_bits.size()) mw[W-1-b] = mosi_bits[i*W+b];
      chk($sformatf("%s_mosi%0d", tag, i), mw, tx_words[i]);
    end
  endtask

  initial begin
    int budget;
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_get", get, 0);
    chk("rst_put", put, 0);
    chk("rst_out", out_w, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Permanently empty source: nothing moves
    div = 2'd3;
    clear_stats();
    repeat (40) @(negedge clock);
    chk("idle_gets", get_cnt, 0);
    chk("idle_puts", put_cnt, 0);
    chk("idle_cs_low", cs_low_cyc, 0);
    chk("idle_rises", rise_cnt, 0);

    // Single loopback word
    miso_mode = 0;
    tx_words = '{8'h55};
    transfer("single55", 3);

    // "hello" burst
    tx_words = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    transfer("hello", 3);

    // Fastest prescaler, miso tied high
    miso_mode = 1;
    tx_words = '{8'h00};
    transfer("div0", 0);
    chk("div0_put_latency", put_cyc - get_cyc, 16);

    // External slave data differs from transmit data
    miso_mode = 2;
    miso_pat = 8'hA3;
    tx_words = '{8'h3C};
    transfer("ext_a3", 1);

    // Reset after 3 bits aborts the word
    miso_mode = 0;
    clear_stats();
    div = 2'd2;
    src_q.push_back(8'hC3);
    budget = 0;
    while (rise_cnt < 3 && budget < 500) begin
      @(negedge clock);
      budget++;
    end
    chk("abort_reach_bit3", rise_cnt, 3);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_put", put, 0);
    repeat (3) @(negedge clock);
    chk("abort_no_put", put_cnt, 0);
    chk("abort_out", out_w, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tx_words = '{8'h9A};
    transfer("after_rst", 2);

    // Randomized bursts
    for (int k = 0; k < 8; k++) begin
      int n;
      miso_mode = int'($urandom_range(0, 2));
      miso_pat  = W'($urandom);
      n = int'($urandom_range(1, 3));
      tx_words.delete();
      for (int j = 0; j < n; j++) tx_words.push_back(W'($urandom));
      transfer($sformatf("rand%0d", k), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
